blink_scheduler: RTL and testbench

Command-driven sequencer for the board's three indicator outputs (LED and two toggle pins). It replaces the free-running fixed-rate toggle with queued blink commands. Each command gives a half-period, a toggle count and an output mask. Commands are accepted over a valid/ready interface into a small FIFO and executed back-to-back in order. Pin passthroughs stay outside this block.

---
 rtl/blink_scheduler_if.sv | 34 +++
 rtl/blink_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_blink_scheduler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/blink_scheduler_if.sv
// Command channel for blink_scheduler.
// Carries one blink command per valid/ready handshake:
//   i_cmd_valid        - producer has a command on the bus
//   o_cmd_ready        - scheduler queue has room (not full)
//   i_cmd_half_period  - cycles between toggles (0 behaves as 1)
//   i_cmd_toggles      - number of toggles to perform
//   i_cmd_mask         - bit0 LED, bit1 out0, bit2 out1
// master: command producer; slave: blink_scheduler.
interface blink_scheduler_if #(
  parameter int PERIOD_W = 27,
  parameter int COUNT_W  = 8
);
  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [PERIOD_W-1:0] i_cmd_half_period;
  logic [COUNT_W-1:0]  i_cmd_toggles;
  logic [2:0]          i_cmd_mask;

  modport master (
    output i_cmd_valid,
    output i_cmd_half_period,
    output i_cmd_toggles,
    output i_cmd_mask,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd_half_period,
    input  i_cmd_toggles,
    input  i_cmd_mask,
    output o_cmd_ready
  );
endinterface

// File: rtl/blink_scheduler.sv
// Queued blink sequencer for the three board indicator outputs.
// Commands arrive over cmd_if into a small FIFO and run back-to-back:
// each one inverts the masked outputs every H cycles, a given number of times.
// Ports:
//   i_clk, i_rst  - clock and synchronous active-high reset
//   cmd_if        - command channel (slave side)
//   i_abort       - flush queue, stop current command, drive outputs low
//   o_led, o_out0, o_out1 - registered indicator outputs
//   o_busy        - command running, queued, or a completion still to report
//   o_done        - one-cycle pulse per completed command
module blink_scheduler #(
  parameter int PERIOD_W   = 27,
  parameter int COUNT_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  blink_scheduler_if.slave cmd_if,
  input  logic             i_abort,
  output logic             o_led,
  output logic             o_out0,
  output logic             o_out1,
  output logic             o_busy,
  output logic             o_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]       FULL_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]       ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0]       ONE_C  = CW'(1);
  localparam logic [AW-1:0]       ONE_A  = AW'(1);
  localparam logic [PERIOD_W-1:0] ZERO_P = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] ONE_P  = PERIOD_W'(1);
  localparam logic [COUNT_W-1:0]  ZERO_T = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0]  ONE_T  = COUNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [PERIOD_W-1:0] hp;
    logic [COUNT_W-1:0]  tog;
    logic [2:0]          mask;
  } cmd_t;

  cmd_t                fifo_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] h_q, h_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0]  rem_q, rem_d;
  logic [2:0]          mask_q, mask_d;
  logic [2:0]          out_q, out_d;
  logic                done_q, done_d;
  // A zero-toggle command popped while another completion is being reported
  // owes its o_done pulse one cycle later.
  logic                zdone_q, zdone_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;

  logic                push_s;
  logic                pop_s;
  logic                empty_s;
  logic                term_s;
  cmd_t                head_s;
  cmd_t                cmd_in_s;
  logic [PERIOD_W-1:0] head_h_s;

  assign cmd_in_s = '{hp: cmd_if.i_cmd_half_period,
                      tog: cmd_if.i_cmd_toggles,
                      mask: cmd_if.i_cmd_mask};
  assign head_s   = fifo_q[rd_ptr_q];
  assign head_h_s = (head_s.hp == ZERO_P) ? ONE_P : head_s.hp;
  assign empty_s  = (count_q == ZERO_C);
  // Abort drops a same-cycle push; ready is registered from the post-edge count.
  assign push_s   = cmd_if.i_cmd_valid && ready_q && !i_abort;
  assign term_s   = (cnt_q == (h_q - ONE_P));

  // Sequencer next state: pops, toggles, completion and abort.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mask_d  = mask_q;
    out_d   = out_q;
    done_d  = 1'b0;
    zdone_d = 1'b0;
    pop_s   = 1'b0;
    if (i_abort) begin
      state_d = IDLE;
      cnt_d   = ZERO_P;
      rem_d   = ZERO_T;
      out_d   = 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          // A pending zero-toggle completion is reported now either way.
          done_d = zdone_q;
          if (!empty_s) begin
            pop_s  = 1'b1;
            h_d    = head_h_s;
            rem_d  = head_s.tog;
            mask_d = head_s.mask;
            cnt_d  = ZERO_P;
            if (head_s.tog == ZERO_T) begin
              state_d = IDLE;
              done_d  = 1'b1;
              zdone_d = zdone_q;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (term_s) begin
            out_d = out_q ^ mask_q;
            cnt_d = ZERO_P;
            rem_d = rem_q - ONE_T;
            if (rem_q == ONE_T) begin
              done_d = 1'b1;
              if (!empty_s) begin
                // Back-to-back: next command's counter starts on this edge.
                pop_s  = 1'b1;
                h_d    = head_h_s;
                rem_d  = head_s.tog;
                mask_d = head_s.mask;
                if (head_s.tog == ZERO_T) begin
                  state_d = IDLE;
                  zdone_d = 1'b1;
                end else begin
                  state_d = RUN;
                end
              end else begin
                state_d = IDLE;
              end
            end else begin
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + ONE_P;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Queue pointer/occupancy next state and derived status outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_abort) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = ZERO_C;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ONE_A;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ONE_A;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
    ready_d = (count_d != FULL_C);
    busy_d  = (state_d == RUN) || (count_d != ZERO_C) || zdone_d;
  end

  // Command storage; entries are written only on an accepted push.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= {$bits(cmd_t){1'b0}};
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= cmd_in_s;
    end
  end

  // State, counters, outputs and queue pointers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      h_q      <= ZERO_P;
      cnt_q    <= ZERO_P;
      rem_q    <= ZERO_T;
      mask_q   <= 3'b000;
      out_q    <= 3'b000;
      done_q   <= 1'b0;
      zdone_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= ZERO_C;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      mask_q   <= mask_d;
      out_q    <= out_d;
      done_q   <= done_d;
      zdone_q  <= zdone_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_led              = out_q[0];
  assign o_out0             = out_q[1];
  assign o_out1             = out_q[2];
  assign o_done             = done_q;
  assign o_busy             = busy_q;
  assign cmd_if.o_cmd_ready = ready_q;

endmodule

// File: tb/tb_blink_scheduler.sv
// Self-checking bench for blink_scheduler: directed scenarios plus random
// traffic, all compared every cycle against an event-time reference model.
module tb_blink_scheduler;
  localparam int PW = 27;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic led, out0, out1, busy, done;

  blink_scheduler_if #(.PERIOD_W(PW), .COUNT_W(CW)) cmd_if ();

  blink_scheduler #(.PERIOD_W(PW), .COUNT_W(CW), .FIFO_DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .cmd_if  (cmd_if),
    .i_abort (abort),
    .o_led   (led),
    .o_out0  (out0),
    .o_out1  (out1),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned hp;
    int unsigned tog;
    int unsigned mask;
  } mcmd_t;

  // Reference model: commands as a queue, toggles and completions as absolute
  // edge numbers.
  mcmd_t       mq[$];
  longint      done_at[$];
  longint      cyc       = 0;
  longint      last_done = -1;
  longint      next_tog  = 0;
  longint      h_cur     = 1;
  bit          act       = 1'b0;
  bit          m_ready   = 1'b1;
  int unsigned left      = 0;
  int unsigned cur_mask  = 0;
  int unsigned m_out     = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic mcmd_t mk(input int unsigned hp, input int unsigned tog, input int unsigned mask);
    mcmd_t c;
    c.hp = hp; c.tog = tog; c.mask = mask;
    return c;
  endfunction

  // Completions are reported one per cycle, in order.
  task automatic m_sched_done();
    longint d;
    d = (last_done >= cyc) ? last_done + 1 : cyc;
    done_at.push_back(d);
    last_done = d;
  endtask

  task automatic m_pop();
    mcmd_t c;
    c = mq.pop_front();
    if (c.tog == 0) begin
      m_sched_done();
    end else begin
      act      = 1'b1;
      left     = c.tog;
      cur_mask = c.mask;
      h_cur    = (c.hp == 0) ? 1 : c.hp;
      next_tog = cyc + h_cur;
    end
  endtask

  function automatic bit m_busy();
    bit b;
    b = act || (mq.size() > 0);
    foreach (done_at[i]) if (done_at[i] > cyc) b = 1'b1;
    return b;
  endfunction

  function automatic bit m_done();
    bit d;
    d = 1'b0;
    foreach (done_at[i]) if (done_at[i] == cyc) d = 1'b1;
    return d;
  endfunction

  task automatic model_step(input bit v, input mcmd_t c, input bit ab, input bit rs);
    bit push;
    cyc++;
    if (rs || ab) begin
      mq.delete();
      done_at.delete();
      act       = 1'b0;
      m_out     = 0;
      last_done = -1;
    end else begin
      push = v && m_ready;
      if (act) begin
        if (cyc == next_tog) begin
          m_out ^= cur_mask;
          left--;
          if (left == 0) begin
            m_sched_done();
            act = 1'b0;
            if (mq.size() > 0) m_pop();
          end else begin
            next_tog = cyc + h_cur;
          end
        end
      end else if (mq.size() > 0) begin
        m_pop();
      end
      if (push) mq.push_back(c);
    end
    m_ready = (mq.size() < 4);
    while (done_at.size() > 0 && done_at[0] < cyc) void'(done_at.pop_front());
  endtask

  task automatic cycle(input bit v, input mcmd_t c, input bit ab, input bit rs);
    cmd_if.i_cmd_valid       = v;
    cmd_if.i_cmd_half_period = PW'(c.hp);
    cmd_if.i_cmd_toggles     = CW'(c.tog);
    cmd_if.i_cmd_mask        = 3'(c.mask);
    abort = ab;
    rst   = rs;
    @(posedge clk);
    model_step(v, c, ab, rs);
    #1;
    chk("led",   {31'b0, led},                {31'b0, m_out[0]});
    chk("out0",  {31'b0, out0},               {31'b0, m_out[1]});
    chk("out1",  {31'b0, out1},               {31'b0, m_out[2]});
    chk("done",  {31'b0, done},               {31'b0, m_done()});
    chk("busy",  {31'b0, busy},               {31'b0, m_busy()});
    chk("ready", {31'b0, cmd_if.o_cmd_ready}, {31'b0, m_ready});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, mk(0, 0, 0), 1'b0, 1'b0);
  endtask

  // Holds valid until the model says the command was taken.
  task automatic push_cmd(input mcmd_t c);
    bit acc;
    int guard;
    guard = 0;
    acc   = 1'b0;
    while (!acc) begin
      acc = m_ready;
      cycle(1'b1, c, 1'b0, 1'b0);
      guard++;
      if (!acc && guard > 500) begin
        chk("push_timeout", 32'd0, 32'd1);
        acc = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((m_busy() || done_at.size() > 0) && g < 3000) begin
      idle(1);
      g++;
    end
    if (g >= 3000) chk("drain_timeout", 32'd0, 32'd1);
    idle(2);
  endtask

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_if.i_cmd_valid       = 1'b0;
    cmd_if.i_cmd_half_period = '0;
    cmd_if.i_cmd_toggles     = '0;
    cmd_if.i_cmd_mask        = 3'b000;
    abort = 1'b0;
    rst   = 1'b1;

    // Reset values.
    cycle(1'b0, mk(0, 0, 0), 1'b0, 1'b1);
    cycle(1'b0, mk(0, 0, 0), 1'b0, 1'b1);
    chk("rst_led",   {31'b0, led},                32'd0);
    chk("rst_ready", {31'b0, cmd_if.o_cmd_ready}, 32'd1);
    chk("rst_busy",  {31'b0, busy},               32'd0);
    chk("rst_done",  {31'b0, done},               32'd0);

    // Single command H=4, 3 toggles on the LED; push edge A, rise after A+5.
    push_cmd(mk(4, 3, 3'b001));
    idle(4);
    chk("tp1_before_rise", {31'b0, led}, 32'd0);
    idle(1);
    chk("tp1_rise", {31'b0, led}, 32'd1);
    drain();

    // Long command then five pushes; the queue fills and back-pressures.
    push_cmd(mk(100, 1, 3'b100));
    idle(2);
    for (int i = 0; i < 5; i++) push_cmd(mk(i + 1, i % 3 + 1, (i % 7) + 1));
    drain();

    // Back-to-back commands with different periods.
    push_cmd(mk(2, 2, 3'b111));
    push_cmd(mk(3, 1, 3'b010));
    drain();

    // Zero toggles, zero half-period, and zero-toggle commands queued behind a run.
    push_cmd(mk(5, 0, 3'b111));
    drain();
    push_cmd(mk(0, 2, 3'b001));
    drain();
    push_cmd(mk(2, 1, 3'b001));
    push_cmd(mk(3, 0, 3'b010));
    push_cmd(mk(1, 0, 3'b100));
    push_cmd(mk(1, 1, 3'b100));
    drain();

    // Abort mid-run with two queued and a simultaneous push.
    push_cmd(mk(20, 4, 3'b111));
    idle(22);
    push_cmd(mk(3, 2, 3'b001));
    push_cmd(mk(4, 2, 3'b010));
    cycle(1'b1, mk(2, 2, 3'b100), 1'b1, 1'b0);
    chk("abort_led",   {31'b0, led},  32'd0);
    chk("abort_out1",  {31'b0, out1}, 32'd0);
    chk("abort_busy",  {31'b0, busy}, 32'd0);
    chk("abort_done",  {31'b0, done}, 32'd0);
    idle(10);
    chk("abort_no_exec", {31'b0, out1}, 32'd0);

    // Reset mid-run with the LED high, then a fresh command.
    push_cmd(mk(10, 3, 3'b001));
    idle(12);
    chk("pre_rst_led", {31'b0, led}, 32'd1);
    cycle(1'b0, mk(0, 0, 0), 1'b0, 1'b1);
    chk("mid_rst_led",   {31'b0, led},                32'd0);
    chk("mid_rst_ready", {31'b0, cmd_if.o_cmd_ready}, 32'd1);
    chk("mid_rst_busy",  {31'b0, busy},               32'd0);
    push_cmd(mk(2, 2, 3'b011));
    drain();

    // Random traffic including aborts, resets and zero fields.
    for (int i = 0; i < 3000; i++) begin
      mcmd_t c;
      bit    v, ab, rs;
      c.hp   = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 20) : $urandom_range(0, 4);
      c.tog  = $urandom_range(0, 3);
      c.mask = $urandom_range(0, 7);
      v  = $urandom_range(0, 1);
      ab = ($urandom_range(0, 149) == 0);
      rs = ($urandom_range(0, 399) == 0);
      cycle(v, c, ab, rs);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
